// File: rtl/prio_enc_q_if.sv
// prio_enc_q_if: request/grant bundle for the prio_enc_q encoder.
// slave = encoder side, master = source/consumer side (testbench or glue).
interface prio_enc_q_if #(
   parameter int N = 8,
   parameter int W = $clog2(N)
);
   logic [N-1:0] req;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;
   logic         busy;
   logic         multi_err;

   modport slave (
      input  req, out_ready,
      output out_valid, out_idx, out_onehot, busy, multi_err
   );

   modport master (
      output req, out_ready,
      input  out_valid, out_idx, out_onehot, busy, multi_err
   );
endinterface

// File: rtl/prio_enc_q.sv
// prio_enc_q: registered N-to-log2(N) priority encoder with sticky pending
// requests and a valid/ready output. RR=0 grants the highest pending index,
// RR=1 rotates the search start past the last grant.
// Optional macro PENC_MULTIHOT_ERR_EN builds the sticky multi-hot detector
// behind multi_err; without it multi_err is tied low.
module prio_enc_q #(
   parameter int N  = 8,
   parameter int W  = $clog2(N),
   parameter int RR = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   prio_enc_q_if.slave bus
);

   logic [N-1:0] r_pend;
   logic [N-1:0] r_onehot;
   logic         r_vld;
   logic [W-1:0] r_idx;

   logic [W-1:0] w_sel;
   logic         w_load;
   logic [N-1:0] w_load_oh;
   logic [N-1:0] w_pend_nxt;

   // A grant can be loaded whenever the output slot is free or being consumed.
   assign w_load     = (!r_vld || bus.out_ready) && (r_pend != '0);
   assign w_load_oh  = w_load ? (N'(1) << w_sel) : '0;
   // A req arriving on the bit being granted re-arms it as a fresh request.
   assign w_pend_nxt = (r_pend & ~w_load_oh) | bus.req;

   generate
      if (RR != 0) begin : g_rr
         logic [W-1:0] r_rr_ptr;

         // Remember the last granted index; reset to N-1 so the first search starts at bit 0.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      r_rr_ptr <= W'(N - 1);
            else if (w_load) r_rr_ptr <= w_sel;
         end

         // Search upward from r_rr_ptr+1, wrapping; the pointer itself is tried last.
         always_comb begin : p_rr_sel
            logic         w_found;
            logic [W-1:0] w_pos;
            w_sel   = '0;
            w_found = 1'b0;
            w_pos   = '0;
            for (int k = 1; k <= N; k++) begin
               w_pos = W'((int'(r_rr_ptr) + k) % N);
               if (!w_found && r_pend[w_pos]) begin
                  w_sel   = w_pos;
                  w_found = 1'b1;
               end
            end
         end
      end else begin : g_fp
         // Fixed priority: last set bit scanned upward is the highest index.
         always_comb begin : p_fp_sel
            w_sel = '0;
            for (int i = 0; i < N; i++) begin
               if (r_pend[i]) w_sel = W'(i);
            end
         end
      end
   endgenerate

   // Pending capture plus output slot load/drain; idx/onehot hold after drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend   <= '0;
         r_vld    <= 1'b0;
         r_idx    <= '0;
         r_onehot <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         if (w_load) begin
            r_vld    <= 1'b1;
            r_idx    <= w_sel;
            r_onehot <= w_load_oh;
         end else if (r_vld && bus.out_ready) begin
            r_vld <= 1'b0;
         end
      end
   end

`ifdef PENC_MULTIHOT_ERR_EN
   logic r_merr;

   // Sticky flag: set whenever more than one req bit is high in a cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_merr <= 1'b0;
      else        r_merr <= r_merr | (|(bus.req & (bus.req - N'(1))));
   end

   assign bus.multi_err = r_merr;
`else
   assign bus.multi_err = 1'b0;
`endif

   assign bus.out_valid  = r_vld;
   assign bus.out_idx    = r_idx;
   assign bus.out_onehot = r_onehot;
   assign bus.busy       = |r_pend;

endmodule

// File: tb/tb_prio_enc_q.sv
// tb_prio_enc_q: drives a fixed-priority (RR=0) and a round-robin (RR=1)
// instance with identical stimulus; directed table, corner sequences and
// random traffic are checked against an abstract per-mode model.
module tb_prio_enc_q;
   localparam int N = 8;
   localparam int W = 3;
`ifdef PENC_MULTIHOT_ERR_EN
   localparam int MERR_EN = 1;
`else
   localparam int MERR_EN = 0;
`endif

   logic clk;
   logic rst_n;

   prio_enc_q_if #(.N(N)) if_fp ();
   prio_enc_q_if #(.N(N)) if_rr ();

   prio_enc_q #(.N(N), .RR(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp));
   prio_enc_q #(.N(N), .RR(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Abstract model: index 0 = fixed priority, 1 = round-robin.
   logic [7:0] m_pend [2];
   logic       m_v    [2];
   int         m_idx  [2];
   logic [7:0] m_oh   [2];
   int         m_last;
   logic       m_err;

   typedef struct {
      logic [7:0] rq;
      logic       rdy;
      logic       v;
      int         idx;
      logic [7:0] oh;
      logic       busy;
   } vec_t;
   vec_t tbl [13];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_pend[m] = '0; m_v[m] = 1'b0; m_idx[m] = 0; m_oh[m] = '0;
      end
      m_last = N - 1;
      m_err  = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] rq, input logic rdy);
      for (int m = 0; m < 2; m++) begin
         int sel;
         sel = -1;
         if (m_pend[m] != 0 && (!m_v[m] || rdy)) begin
            if (m == 0) begin
               for (int i = N - 1; i >= 0; i--)
                  if (sel < 0 && m_pend[m][i]) sel = i;
            end else begin
               for (int k = 1; k <= N; k++)
                  if (sel < 0 && m_pend[m][(m_last + k) % N]) sel = (m_last + k) % N;
            end
         end
         if (sel >= 0) begin
            m_pend[m][sel] = 1'b0;
            m_v[m]   = 1'b1;
            m_idx[m] = sel;
            m_oh[m]  = '0;
            m_oh[m][sel] = 1'b1;
            if (m == 1) m_last = sel;
         end else if (m_v[m] && rdy) begin
            m_v[m] = 1'b0;
         end
         m_pend[m] = m_pend[m] | rq;
      end
      if (MERR_EN != 0 && $countones(rq) > 1) m_err = 1'b1;
   endtask

   task automatic check_all();
      chk("fp_valid",  int'(if_fp.out_valid),  int'(m_v[0]));
      chk("fp_idx",    int'(if_fp.out_idx),    m_idx[0]);
      chk("fp_onehot", int'(if_fp.out_onehot), int'(m_oh[0]));
      chk("fp_busy",   int'(if_fp.busy),       int'(m_pend[0] != 0));
      chk("fp_merr",   int'(if_fp.multi_err),  int'(m_err));
      chk("rr_valid",  int'(if_rr.out_valid),  int'(m_v[1]));
      chk("rr_idx",    int'(if_rr.out_idx),    m_idx[1]);
      chk("rr_onehot", int'(if_rr.out_onehot), int'(m_oh[1]));
      chk("rr_busy",   int'(if_rr.busy),       int'(m_pend[1] != 0));
      chk("rr_merr",   int'(if_rr.multi_err),  int'(m_err));
   endtask

   // Drive inputs, let one rising edge happen, then sample 1 time unit later.
   task automatic cycle(input logic [7:0] rq, input logic rdy);
      if_fp.req = rq; if_fp.out_ready = rdy;
      if_rr.req = rq; if_rr.out_ready = rdy;
      @(posedge clk);
      model_step(rq, rdy);
      #1;
      check_all();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_fp_valid"},  int'(if_fp.out_valid),  0);
      chk({tag, "_fp_idx"},    int'(if_fp.out_idx),    0);
      chk({tag, "_fp_onehot"}, int'(if_fp.out_onehot), 0);
      chk({tag, "_fp_busy"},   int'(if_fp.busy),       0);
      chk({tag, "_fp_merr"},   int'(if_fp.multi_err),  0);
      chk({tag, "_rr_valid"},  int'(if_rr.out_valid),  0);
      chk({tag, "_rr_busy"},   int'(if_rr.busy),       0);
      chk({tag, "_rr_merr"},   int'(if_rr.multi_err),  0);
   endtask

   // Async reset pulse taken between edges, released on a falling edge.
   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 chk_all_zero(tag);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] w_dummy;
      w_dummy = '0;
      rst_n = 1'b0;
      if_fp.req = '0; if_fp.out_ready = 1'b0;
      if_rr.req = '0; if_rr.out_ready = 1'b0;
      model_reset();

      tbl[0]  = '{8'h20, 1'b1, 1'b0, 0, 8'h00, 1'b1};
      tbl[1]  = '{8'h00, 1'b1, 1'b1, 5, 8'h20, 1'b0};
      tbl[2]  = '{8'h00, 1'b1, 1'b0, 5, 8'h20, 1'b0};
      tbl[3]  = '{8'h81, 1'b1, 1'b0, 5, 8'h20, 1'b1};
      tbl[4]  = '{8'h00, 1'b1, 1'b1, 7, 8'h80, 1'b1};
      tbl[5]  = '{8'h00, 1'b1, 1'b1, 0, 8'h01, 1'b0};
      tbl[6]  = '{8'h00, 1'b1, 1'b0, 0, 8'h01, 1'b0};
      tbl[7]  = '{8'h04, 1'b0, 1'b0, 0, 8'h01, 1'b1};
      tbl[8]  = '{8'h00, 1'b0, 1'b1, 2, 8'h04, 1'b0};
      tbl[9]  = '{8'h40, 1'b0, 1'b1, 2, 8'h04, 1'b1};
      tbl[10] = '{8'h00, 1'b0, 1'b1, 2, 8'h04, 1'b1};
      tbl[11] = '{8'h00, 1'b1, 1'b1, 6, 8'h40, 1'b0};
      tbl[12] = '{8'h00, 1'b1, 1'b0, 6, 8'h40, 1'b0};

      repeat (3) @(posedge clk);
      #1 chk_all_zero("rst_init");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed fixed-priority table: single pulse, 0x81 ordering, backpressure.
      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].rq, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i),  int'(if_fp.out_valid),  int'(tbl[i].v));
         chk($sformatf("tbl%0d_idx", i),    int'(if_fp.out_idx),    tbl[i].idx);
         chk($sformatf("tbl%0d_onehot", i), int'(if_fp.out_onehot), int'(tbl[i].oh));
         chk($sformatf("tbl%0d_busy", i),   int'(if_fp.busy),       int'(tbl[i].busy));
      end

      // Mid-stream reset with pending=0x3C and a held grant.
      cycle(8'h3C, 1'b0);
      cycle(8'h3C, 1'b0);
      chk("pre_rst_valid", int'(if_fp.out_valid), 1);
      chk("pre_rst_busy",  int'(if_fp.busy),      1);
      pulse_reset("rst_mid");
      cycle(8'h00, 1'b1);
      cycle(8'h00, 1'b1);
      chk("post_rst_valid", int'(if_fp.out_valid), 0);
      chk("post_rst_busy",  int'(if_fp.busy),      0);

      // Round-robin with 0x11 held: 0,4,0,4,... right after reset.
      cycle(8'h11, 1'b1);
      for (int j = 0; j < 8; j++) begin
         cycle(8'h11, 1'b1);
         chk($sformatf("rr%0d_valid", j), int'(if_rr.out_valid), 1);
         chk($sformatf("rr%0d_idx", j),   int'(if_rr.out_idx),   (j % 2 == 0) ? 0 : 4);
         chk($sformatf("fp%0d_idx", j),   int'(if_fp.out_idx),   4);
      end
      repeat (4) cycle(8'h00, 1'b1);

      // Sticky multi-hot flag.
      pulse_reset("rst_merr");
      cycle(8'h08, 1'b1);
      chk("merr_onehot", int'(if_fp.multi_err), 0);
      cycle(8'h03, 1'b1);
      chk("merr_set", int'(if_fp.multi_err), MERR_EN);
      cycle(8'h10, 1'b1);
      cycle(8'h01, 1'b1);
      chk("merr_sticky", int'(if_rr.multi_err), MERR_EN);
      repeat (3) cycle(8'h00, 1'b1);
      pulse_reset("rst_merr_clr");

      // Random sparse traffic with random backpressure.
      for (int i = 0; i < 600; i++) begin
         logic [7:0] rq;
         logic       rdy;
         rq  = 8'($urandom) & 8'($urandom) & 8'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
         cycle(rq, rdy);
         if (i == 300) pulse_reset("rst_rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/prio_enc_q.md
Name: prio_enc_q

Overview:
- Parametrised, registered N-to-log2(N) priority encoder that succeeds the team's fixed 4-to-2 combinational encoder.
- Request bits are captured into a sticky pending register, so no request is lost.
- Requests are encoded one at a time, either by fixed priority or by round-robin, and presented on a valid/ready output port.
- Sits between interrupt/event sources and a downstream consumer (controller FSM or FIFO) that may apply backpressure.

Parameters:
- N, 8, number of request inputs (>=2).
- W, $clog2(N), index width; derived, do not override.
- RR, 0, arbitration mode: 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  N  request bits, sampled every cycle, any number may be high.
- out_ready  in  1  consumer accepts the output when high.
- out_valid  out  1  out_idx/out_onehot hold a grant.
- out_idx  out  W  binary index of the granted request.
- out_onehot  out  N  one-hot form of out_idx.
- busy  out  1  high when any request is pending (not yet loaded to output).
- multi_err  out  1  sticky multi-hot flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync-safe deassert via flop reset) clears the following: pending=0, out_valid=0, out_idx=0, out_onehot=0, multi_err=0, rr_ptr=N-1.
- Pending update each cycle: pending_next = (pending & ~load_onehot) | req.
  - A req bit high in the same cycle its pending bit is loaded stays pending; it counts as a new request.
- Load condition: load = (!out_valid || out_ready) && (pending != 0).
- Load action: out_valid<=1, out_idx<=sel, out_onehot<=1<<sel, and the sel bit is cleared from pending.
- Drain: if (out_valid && out_ready && pending==0), out_valid<=0. out_idx/out_onehot keep their last values.
- Selection uses registered pending only, never the current req.
- Latency: req pulse at edge t is pending after t+1 and appears on out_valid after t+2 (minimum 2 cycles).
- Throughput: one grant per cycle while out_ready=1 and pending is non-zero.
- Backpressure: while out_valid=1 and out_ready=0, out_valid, out_idx and out_onehot are stable; new reqs accumulate in pending.
- RR=0: sel = highest set index of pending.
- RR=1:
  - sel = first set bit searching upward from rr_ptr+1, wrapping N-1 -> 0.
  - On each load, rr_ptr<=sel.
  - After reset the first search starts at bit 0.
  - With a single pending bit, that bit is granted regardless of rr_ptr.
- busy = |pending (registered state, combinational OR).
- Repeated req on an already-pending bit merges; no counting.
- Reset mid-operation: pending requests and any held output are discarded immediately; nothing is replayed.

Optional Feature:
- Macro: PENC_MULTIHOT_ERR_EN.
- Defined:
  - multi_err sets on any cycle where req has more than one bit high (popcount>1).
  - It stays set until rst_n assertion.
  - Detection does not affect arbitration.
- Undefined: multi_err is tied to 0 and no detection logic is built.

Test Plan (N=8):
- Reset: assert rst_n=0 mid-stream with pending=0x3C and out_valid=1 -> all outputs 0 asynchronously. After release, busy=0 and out_valid=0 until a new req.
- Single pulse, RR=0, out_ready=1: req=0x20 for 1 cycle at edge t -> out_valid=1, out_idx=5, out_onehot=0x20 after edge t+2 for exactly one cycle; busy=0 afterwards.
- Fixed priority, RR=0: req=0x81 pulse, out_ready=1 -> grants idx 7 then idx 0 on consecutive cycles, then out_valid=0.
- Backpressure, RR=0, out_ready=0:
  - req=0x04 pulse -> out_valid=1, idx=2, held stable.
  - Then req=0x40 pulse -> busy=1 while idx stays 2.
  - Raise out_ready -> next cycle idx=6, then out_valid=0.
- Round-robin, RR=1: req=0x11 held high, out_ready=1 -> grants 0,4,0,4,... alternating, with no starvation.
- With PENC_MULTIHOT_ERR_EN defined: req=0x03 for 1 cycle -> multi_err=1 and stays 1 through later one-hot reqs until rst_n=0. Without the macro, multi_err stays 0.
